lcd_timing_gen: RTL

Parametrised display timing generator and test-pattern source for parallel-RGB LCD panels.
- Produces DE/HSYNC/VSYNC, pixel coordinates and 24-bit RGB, all registered.
- Provides an early fetch strobe so a downstream pixel pipeline (font ROM, FIFO, framebuffer) of configurable depth lines up exactly with DE.
- Sits between the pixel clock DCM and the panel connector pins.

---
 rtl/lcd_timing_gen_if.sv | 32 +++
 rtl/lcd_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen_if.sv
// Signal bundle between the display controller and lcd_timing_gen:
// control inputs, early fetch strobe/coordinates and the registered panel outputs.
interface lcd_timing_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        fetch_en;
  logic [9:0]  fetch_x;
  logic [9:0]  fetch_y;
  logic        frame_start;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  // master is the controller/pixel-pipeline side, slave is the timing generator
  modport master (
    output enable, pattern_sel, solid_rgb,
    input  fetch_en, fetch_x, fetch_y, frame_start,
    input  de, hsync, vsync, x, y, r, g, b
  );

  modport slave (
    input  enable, pattern_sel, solid_rgb,
    output fetch_en, fetch_x, fetch_y, frame_start,
    output de, hsync, vsync, x, y, r, g, b
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD timing generator with test patterns and an early fetch strobe.
// Build option LCD_SYNC_OUT_EN: generate HSYNC/VSYNC; when undefined they are tied inactive.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DELAY    = 16,
  parameter bit SYNC_POL = 1'b0,
  parameter int CHK_BIT  = 7
) (
  input  logic               pixel_clk,
  input  logic               rst,
  lcd_timing_gen_if.slave    bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
`ifdef LCD_SYNC_OUT_EN
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
`endif

  typedef struct packed {
    logic       act;
    logic [1:0] pat;
    logic [9:0] h;
    logic [9:0] v;
`ifdef LCD_SYNC_OUT_EN
    logic       hs;
    logic       vs;
`endif
  } pix_t;

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic        act_s;
  logic        fetch_en_s;
  logic        frame_start_s;
  logic [1:0]  pat_eff_s;
  pix_t        st0_s;
  pix_t        tail_s;
  logic [2:0]  bar_idx_s;
  logic [23:0] rgb_s;

  logic        de_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [23:0] rgb_q;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      3'd7:    c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Counter next state: hold at origin while disabled so re-enable starts at (0,0)
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!bus.enable) begin
      h_cnt_d = 10'd0;
      v_cnt_d = 10'd0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // Raster counters
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0; rst gates the strobes so they are quiet during the async clear
  always_comb begin
    act_s         = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    fetch_en_s    = act_s && bus.enable && !rst;
    frame_start_s = bus.enable && !rst && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    pat_eff_s     = frame_start_s ? bus.pattern_sel : pat_q;
    pat_d         = pat_eff_s;
    st0_s         = '0;
    st0_s.act     = fetch_en_s;
    st0_s.pat     = pat_eff_s;
    st0_s.h       = h_cnt_q;
    st0_s.v       = v_cnt_q;
`ifdef LCD_SYNC_OUT_EN
    st0_s.hs      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    st0_s.vs      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
`endif
  end

  assign bus.fetch_en    = fetch_en_s;
  assign bus.fetch_x     = act_s ? h_cnt_q : 10'd0;
  assign bus.fetch_y     = act_s ? v_cnt_q : 10'd0;
  assign bus.frame_start = frame_start_s;

  // Pattern latch, only moves at frame_start so a frame never mixes patterns
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pat_q <= 2'd0;
    end else begin
      pat_q <= pat_d;
    end
  end

  // DELAY-1 shift stages; the output register supplies the last cycle of lead
  generate
    if (DELAY > 1) begin : g_pipe
      pix_t pipe_q [DELAY-1];

      // Shift register carrying stage-0 attributes towards the output register
      always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= st0_s;
          for (int i = 1; i < DELAY - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign tail_s = pipe_q[DELAY-2];
    end else begin : g_nopipe
      assign tail_s = st0_s;
    end
  endgenerate

  // Pattern colour from delayed coordinates; bar edges are constant compares
  always_comb begin
    bar_idx_s = 3'd0;
    rgb_s     = 24'h000000;
    for (int k = 1; k < 8; k++) begin
      if (tail_s.h >= 10'(k * BAR_W)) begin
        bar_idx_s = 3'(k);
      end else begin
        bar_idx_s = bar_idx_s;
      end
    end
    if (tail_s.act) begin
      case (tail_s.pat)
        2'd0:    rgb_s = (tail_s.h[CHK_BIT] ^ tail_s.v[CHK_BIT]) ? 24'hFFFFFF : 24'h000000;
        2'd1:    rgb_s = bar_colour(bar_idx_s);
        2'd2:    rgb_s = {tail_s.h[7:0], tail_s.v[7:0], ~tail_s.h[7:0]};
        2'd3:    rgb_s = bus.solid_rgb;
        default: rgb_s = 24'h000000;
      endcase
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Output register: blanking forces coordinates and colour to zero
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      de_q  <= 1'b0;
      x_q   <= 10'd0;
      y_q   <= 10'd0;
      rgb_q <= 24'h000000;
    end else begin
      de_q  <= tail_s.act;
      x_q   <= tail_s.act ? tail_s.h : 10'd0;
      y_q   <= tail_s.act ? tail_s.v : 10'd0;
      rgb_q <= rgb_s;
    end
  end

`ifdef LCD_SYNC_OUT_EN
  logic hsync_q;
  logic vsync_q;

  // Sync outputs, polarity applied at the pin register
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      hsync_q <= tail_s.hs ? SYNC_POL : ~SYNC_POL;
      vsync_q <= tail_s.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
`else
  assign bus.hsync = ~SYNC_POL;
  assign bus.vsync = ~SYNC_POL;
`endif

  assign bus.de = de_q;
  assign bus.x  = x_q;
  assign bus.y  = y_q;
  assign bus.r  = rgb_q[23:16];
  assign bus.g  = rgb_q[15:8];
  assign bus.b  = rgb_q[7:0];

endmodule
